decode_stage: RTL and testbench
===============================

# decode_stage

Instruction decode and operand-issue stage for the 16-bit processor, sitting directly upstream of the ALU. It accepts a 16-bit instruction from fetch over a valid/ready handshake and reads operands from an internal 16×16 register file. It tracks outstanding writes with a scoreboard and drives a registered ALU command (func, OP0, OP1, flag_en, flag_in). ALU results and flags return through a write-back port into the register file and the flag register.

## Interface
- DATA_W, 16, operand/register width
- NREGS, 16, register count; R0 reads zero, writes to it are ignored

- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- instr_valid  in  1  fetch has an instruction
- instr  in  16  [15:12] op, [11:8] rd, [7:4] rs, [3:0] rt/imm4
- instr_ready  out  1  stage accepts instr this cycle
- alu_valid  out  1  ALU command valid
- alu_ready  in  1  ALU/downstream consumes the command
- func  out  4  ALU function (= op)
- OP0, OP1  out  DATA_W  ALU operands
- flag_en  out  1  ALU updates flags
- flag_in  out  4  current flag register
- dest  out  4  destination register
- dest_we  out  1  result is written to dest
- wb_en  in  1  register write-back strobe
- wb_addr  in  4  write-back register
- wb_data  in  DATA_W  write-back value
- wb_flag_en  in  1  flag write-back strobe
- wb_flags  in  4  flags from ALU flag_out

## Operation
- Opcodes: 0 JMP, 1 ADD, 2 SUB, 3 LSL, 4 LSR, 5 AND, 6 OR, 7 XOR, 8 LD, 9 ST, 10 MOV, 11 BEQ, 12 BNE, 13 BLT, 14 BGT, 15 CMP.
- Operands:
  - ops 1–7 and CMP: OP0=R[rs], OP1=R[rt].
  - LD/ST: OP0=R[rs], OP1=zero-extended imm4.
  - MOV: OP0=R[rs], OP1=0.
  - JMP/branches: OP0=R[rs], OP1=0.
- dest_we=1 for ops 1–8 and MOV, only when rd≠0. All other ops have dest_we=0. dest=rd.
- flag_en=1 for ops 1–7 and CMP, else 0.
- Scoreboard: one pending bit per register plus a flags-pending bit.
  - Set on issue, for dest when dest_we=1 and for flags when flag_en=1.
  - Cleared by wb_en at wb_addr, or by wb_flag_en for flags.
  - Same register set and cleared in the same edge: set wins.
- Hazard when any of these is pending:
  - a source register read by the op;
  - flags, for branches (11–14);
  - rd, for an op with dest_we (WAW).
- instr_ready = (!alu_valid || alu_ready) && !hazard. Accept when instr_valid && instr_ready.
- Write-back updates the register file and the flag register on the edge. Writes to R0 are dropped.

## Timing
- Reset values:
  - alu_valid, func, OP0, OP1, flag_en, flag_in, dest, dest_we: 0.
  - All registers, flags and pending bits: 0.
  - instr_ready is 1 once rst deasserts.
- Latency: instruction accepted at edge N gives alu_valid=1 with the command after edge N.
- Back-to-back issue every cycle when there are no hazards and alu_ready=1.
- While alu_valid && !alu_ready, all command outputs are held stable and instr_ready=0.
- alu_valid drops after the consuming edge unless a new instruction is accepted on that same edge.
- Reset asserted mid-operation clears the in-flight command and the scoreboard immediately (asynchronously).

## Configuration
- WB_BYPASS_EN defined: a same-cycle wb_en/wb_flag_en matching a source register or the flags forwards wb_data/wb_flags into OP0/OP1/flag_in and clears that hazard. Issue proceeds that cycle.
- Not defined: no forwarding. The hazard holds until the edge that commits write-back, which costs one stall cycle.

## Structure
- Shared header/package isa_defs: opcode constants, field bit positions, DATA_W, and the flag bit order {N,Z,C,V}.
- Sub-module regfile: NREGS×DATA_W, two asynchronous read ports, one synchronous write port, R0 hardwired to zero.
- Scoreboard, decode and the output register live in decode_stage.

## Test plan
- Reset, then instr=0x1123 (ADD r1,r2,r3) with R2=5, R3=7 preloaded via wb → next cycle func=1, OP0=5, OP1=7, dest=1, dest_we=1, flag_en=1.
- ADD r1 issued, then SUB r4,r1,r2 presented → instr_ready=0 until wb_en, wb_addr=1. With WB_BYPASS_EN, wb_data=0x000C in that cycle issues with OP0=0x000C; without it, issue is one cycle later.
- BEQ presented after CMP with no wb_flag_en → stalled. wb_flags=4'b0100 → BEQ issues with flag_in=4'b0100.
- alu_ready=0 for 3 cycles with a command valid → outputs unchanged, instr_ready=0. alu_ready=1 → next instruction is accepted on that edge.
- MOV r0,r5 → dest_we=0, no pending bit set. A following read of r0 gives OP0=0.
- rst asserted while alu_valid=1 and r1 pending → alu_valid=0 immediately. After release, an instruction reading r1 issues with no stall and OP0=0.

Source files
------------

// File: rtl/isa_defs.sv
// Shared ISA definitions for the 16-bit processor.
// Contents: operand width, register count, instruction field positions,
// opcode encoding, flag bit order {N,Z,C,V} and small opcode-class helpers
// used by the decode stage.
package isa_defs;

  localparam int DATA_W = 16;
  localparam int NREGS  = 16;
  localparam int REG_AW = 4;

  // Instruction fields: [15:12] op, [11:8] rd, [7:4] rs, [3:0] rt/imm4
  localparam int OP_LSB = 12;
  localparam int RD_LSB = 8;
  localparam int RS_LSB = 4;
  localparam int RT_LSB = 0;

  // Flag register bit order {N,Z,C,V}
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [3:0] {
    OP_JMP = 4'd0,  OP_ADD = 4'd1,  OP_SUB = 4'd2,  OP_LSL = 4'd3,
    OP_LSR = 4'd4,  OP_AND = 4'd5,  OP_OR  = 4'd6,  OP_XOR = 4'd7,
    OP_LD  = 4'd8,  OP_ST  = 4'd9,  OP_MOV = 4'd10, OP_BEQ = 4'd11,
    OP_BNE = 4'd12, OP_BLT = 4'd13, OP_BGT = 4'd14, OP_CMP = 4'd15
  } opcode_e;

  // ALU ops and CMP read rt and update flags
  function automatic logic is_alu_rr(input logic [3:0] op);
    return (op inside {[OP_ADD:OP_XOR], OP_CMP});
  endfunction

  function automatic logic writes_dest(input logic [3:0] op);
    return (op inside {[OP_ADD:OP_LD], OP_MOV});
  endfunction

  function automatic logic is_branch(input logic [3:0] op);
    return (op inside {[OP_BEQ:OP_BGT]});
  endfunction

  function automatic logic uses_imm4(input logic [3:0] op);
    return (op inside {OP_LD, OP_ST});
  endfunction

endpackage

// File: rtl/regfile.sv
// Register file: NREGS x DATA_W, two asynchronous read ports, one
// synchronous write port. R0 always reads zero and ignores writes.
// Ports:
//   clk, rst        clock, async active-high reset (clears all registers)
//   we, waddr, wdata write port (committed on rising edge)
//   raddr0/rdata0   read port 0
//   raddr1/rdata1   read port 1
module regfile
  import isa_defs::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [REG_AW-1:0] raddr0,
  output logic [DATA_W-1:0] rdata0,
  input  logic [REG_AW-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1
);

  logic [DATA_W-1:0] regs [NREGS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (we && (waddr != '0)) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata0 = (raddr0 == '0) ? '0 : regs[raddr0];
  assign rdata1 = (raddr1 == '0) ? '0 : regs[raddr1];

endmodule

// File: rtl/decode_stage.sv
// Instruction decode and operand-issue stage feeding the ALU.
// Accepts an instruction over valid/ready, reads operands from the register
// file, tracks outstanding register/flag writes in a scoreboard and drives a
// registered ALU command. Write-back returns results and flags.
// Build option: WB_BYPASS_EN forwards same-cycle write-back data/flags into
// the issuing command and clears the matching hazard.
// Ports:
//   clk, rst                       clock, async active-high reset
//   instr_valid, instr, instr_ready fetch handshake
//   alu_valid, alu_ready           ALU command handshake
//   func, OP0, OP1, flag_en, flag_in, dest, dest_we  registered command
//   wb_en, wb_addr, wb_data        register write-back
//   wb_flag_en, wb_flags           flag write-back
module decode_stage
  import isa_defs::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  input  logic [15:0]       instr,
  output logic              instr_ready,
  output logic              alu_valid,
  input  logic              alu_ready,
  output logic [3:0]        func,
  output logic [DATA_W-1:0] OP0,
  output logic [DATA_W-1:0] OP1,
  output logic              flag_en,
  output logic [3:0]        flag_in,
  output logic [3:0]        dest,
  output logic              dest_we,
  input  logic              wb_en,
  input  logic [3:0]        wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              wb_flag_en,
  input  logic [3:0]        wb_flags
);

  logic [3:0]        op, rd, rs, rt;
  logic              d_dest_we, d_flag_en, d_reads_rt, d_branch;
  logic [DATA_W-1:0] rf_rs, rf_rt, rs_val, rt_val, op1_val;
  logic [3:0]        flags_q, fl_val;
  logic [NREGS-1:0]  pend_q, pend_nxt;
  logic              fpend_q, fpend_nxt;
  logic              fwd_rs, fwd_rt, fwd_fl;
  logic              hazard, accept;

  assign op = instr[OP_LSB +: 4];
  assign rd = instr[RD_LSB +: 4];
  assign rs = instr[RS_LSB +: 4];
  assign rt = instr[RT_LSB +: 4];

  assign d_dest_we  = writes_dest(op) && (rd != 4'd0);
  assign d_flag_en  = is_alu_rr(op);
  assign d_reads_rt = is_alu_rr(op);
  assign d_branch   = is_branch(op);

  regfile u_regfile (
    .clk    (clk),
    .rst    (rst),
    .we     (wb_en),
    .waddr  (wb_addr),
    .wdata  (wb_data),
    .raddr0 (rs),
    .rdata0 (rf_rs),
    .raddr1 (rt),
    .rdata1 (rf_rt)
  );

`ifdef WB_BYPASS_EN
  // R0 is never forwarded: writes to it are dropped, so it must stay zero.
  assign fwd_rs = wb_en && (wb_addr == rs) && (rs != 4'd0);
  assign fwd_rt = wb_en && (wb_addr == rt) && (rt != 4'd0);
  assign fwd_fl = wb_flag_en;
`else
  assign fwd_rs = 1'b0;
  assign fwd_rt = 1'b0;
  assign fwd_fl = 1'b0;
`endif

  assign rs_val = fwd_rs ? wb_data  : rf_rs;
  assign rt_val = fwd_rt ? wb_data  : rf_rt;
  assign fl_val = fwd_fl ? wb_flags : flags_q;

  always_comb begin
    op1_val = '0;
    if (d_reads_rt)     op1_val = rt_val;
    else if (uses_imm4(op)) op1_val = {{(DATA_W-4){1'b0}}, rt};
  end

  // rs is read by every opcode; WAW is not forwarded even with bypass.
  assign hazard = (pend_q[rs] && !fwd_rs)
                | (d_reads_rt && pend_q[rt] && !fwd_rt)
                | (d_branch && fpend_q && !fwd_fl)
                | (d_dest_we && pend_q[rd]);

  assign instr_ready = (!alu_valid || alu_ready) && !hazard;
  assign accept      = instr_valid && instr_ready;

  // Clear first, then set, so an issue on the same edge as a write-back
  // to the same register leaves it pending.
  always_comb begin
    pend_nxt  = pend_q;
    fpend_nxt = fpend_q;
    if (wb_en)      pend_nxt[wb_addr] = 1'b0;
    if (wb_flag_en) fpend_nxt = 1'b0;
    if (accept && d_dest_we) pend_nxt[rd] = 1'b1;
    if (accept && d_flag_en) fpend_nxt = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q  <= '0;
      fpend_q <= 1'b0;
      flags_q <= '0;
    end else begin
      pend_q  <= pend_nxt;
      fpend_q <= fpend_nxt;
      if (wb_flag_en) flags_q <= wb_flags;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_valid <= 1'b0;
      func      <= '0;
      OP0       <= '0;
      OP1       <= '0;
      flag_en   <= 1'b0;
      flag_in   <= '0;
      dest      <= '0;
      dest_we   <= 1'b0;
    end else if (accept) begin
      alu_valid <= 1'b1;
      func      <= op;
      OP0       <= rs_val;
      OP1       <= op1_val;
      flag_en   <= d_flag_en;
      flag_in   <= fl_val;
      dest      <= rd;
      dest_we   <= d_dest_we;
    end else if (alu_ready) begin
      alu_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic [15:0] instr;
  logic        instr_ready;
  logic        alu_valid;
  logic        alu_ready;
  logic [3:0]  func;
  logic [15:0] OP0, OP1;
  logic        flag_en;
  logic [3:0]  flag_in;
  logic [3:0]  dest;
  logic        dest_we;
  logic        wb_en;
  logic [3:0]  wb_addr;
  logic [15:0] wb_data;
  logic        wb_flag_en;
  logic [3:0]  wb_flags;

  int n_tests = 0;
  int n_fail  = 0;

  decode_stage dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .alu_valid(alu_valid), .alu_ready(alu_ready),
    .func(func), .OP0(OP0), .OP1(OP1), .flag_en(flag_en), .flag_in(flag_in),
    .dest(dest), .dest_we(dest_we), .wb_en(wb_en), .wb_addr(wb_addr),
    .wb_data(wb_data), .wb_flag_en(wb_flag_en), .wb_flags(wb_flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    instr_valid = 1'b0;
    wb_en       = 1'b0;
    wb_flag_en  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    instr = 16'h0;
    alu_ready = 1'b1;
    wb_addr = 0; wb_data = 0; wb_flags = 0;
    tick(); tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic wb_write(input logic [3:0] a, input logic [15:0] d, input logic fl);
    wb_en = (a != 0); wb_addr = a; wb_data = d;
    wb_flag_en = fl; wb_flags = 4'b0000;
    tick();
    wb_en = 1'b0; wb_flag_en = 1'b0;
  endtask

  // ---------------- behavioural reference (from the ISA rules) -------------
  function automatic bit m_fe(input bit [3:0] op);
    return (op >= 1 && op <= 7) || op == 15;
  endfunction
  function automatic bit m_dwe(input bit [3:0] op, input bit [3:0] rd);
    return ((op >= 1 && op <= 8) || op == 10) && rd != 0;
  endfunction
  function automatic bit m_br(input bit [3:0] op);
    return op >= 11 && op <= 14;
  endfunction

  typedef struct {
    bit valid; bit [3:0] func; bit [15:0] op0, op1;
    bit fe; bit [3:0] fin; bit [3:0] dest; bit dwe;
  } cmd_t;
  typedef struct { bit we; bit [3:0] addr; bit fl; } wbreq_t;

  bit [15:0] m_regs [16];
  bit [3:0]  m_flags;
  bit        m_pend [16];
  bit        m_fpend;
  cmd_t      m_cmd;
  wbreq_t    wbq [$];

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin m_regs[i] = 0; m_pend[i] = 0; end
    m_flags = 0; m_fpend = 0; m_cmd = '{default:0}; wbq.delete();
  endtask

  task automatic random_cycle();
    bit [3:0] op, rd, rs, rt;
    bit fr, ft, ff, haz, exp_ready, consumed, acc;
    bit [15:0] vrs, vrt;
    bit [3:0] vfl;
    cmd_t nc;
    wbreq_t w;
    instr_valid = ($urandom_range(0, 3) != 0);
    instr       = 16'($urandom);
    alu_ready   = ($urandom_range(0, 3) != 0);
    wb_en = 0; wb_flag_en = 0;
    wb_addr = 4'($urandom); wb_data = 16'($urandom); wb_flags = 4'($urandom);
    if (wbq.size() > 0 && $urandom_range(0, 1) == 1) begin
      w = wbq.pop_front();
      wb_en = w.we; wb_addr = w.addr; wb_flag_en = w.fl;
    end
    #1;
    op = instr[15:12]; rd = instr[11:8]; rs = instr[7:4]; rt = instr[3:0];
`ifdef WB_BYPASS_EN
    fr = wb_en && wb_addr == rs && rs != 0;
    ft = wb_en && wb_addr == rt && rt != 0;
    ff = wb_flag_en;
`else
    fr = 0; ft = 0; ff = 0;
`endif
    vrs = fr ? wb_data : m_regs[rs];
    vrt = ft ? wb_data : m_regs[rt];
    vfl = ff ? wb_flags : m_flags;
    haz = (m_pend[rs] && !fr) || (m_fe(op) && m_pend[rt] && !ft) ||
          (m_br(op) && m_fpend && !ff) || (m_dwe(op, rd) && m_pend[rd]);
    exp_ready = (!m_cmd.valid || alu_ready) && !haz;
    chk("rnd_ready", instr_ready, exp_ready);
    chk("rnd_valid", alu_valid, m_cmd.valid);
    if (m_cmd.valid)
      chk("rnd_cmd", {func, OP0, OP1, flag_en, flag_in, dest, dest_we},
          {m_cmd.func, m_cmd.op0, m_cmd.op1, m_cmd.fe, m_cmd.fin, m_cmd.dest, m_cmd.dwe});
    consumed = m_cmd.valid && alu_ready;
    acc = instr_valid && exp_ready;
    if (consumed && (m_cmd.dwe || m_cmd.fe))
      wbq.push_back('{we: m_cmd.dwe, addr: m_cmd.dest, fl: m_cmd.fe});
    if (wb_en && wb_addr != 0) m_regs[wb_addr] = wb_data;
    if (wb_en) m_pend[wb_addr] = 0;
    if (wb_flag_en) begin m_flags = wb_flags; m_fpend = 0; end
    if (acc) begin
      nc.valid = 1; nc.func = op; nc.op0 = vrs;
      nc.op1 = m_fe(op) ? vrt : ((op == 8 || op == 9) ? {12'h000, rt} : 16'h0);
      nc.fe = m_fe(op); nc.fin = vfl; nc.dest = rd; nc.dwe = m_dwe(op, rd);
      if (nc.dwe) m_pend[rd] = 1;
      if (nc.fe) m_fpend = 1;
      m_cmd = nc;
    end else if (alu_ready) begin
      m_cmd.valid = 0;
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [15:0] instr; logic [3:0] func; logic [15:0] op0, op1;
    logic [3:0] dest; logic dwe, fe;
  } vec_t;
  vec_t vecs [10];

  initial begin
    vecs[0] = '{16'h1123, 4'd1,  16'h0202, 16'h0303, 4'd1,  1'b1, 1'b1};
    vecs[1] = '{16'h2456, 4'd2,  16'h0505, 16'h0606, 4'd4,  1'b1, 1'b1};
    vecs[2] = '{16'h8A7C, 4'd8,  16'h0707, 16'h000C, 4'd10, 1'b1, 1'b0};
    vecs[3] = '{16'h93F5, 4'd9,  16'h0F0F, 16'h0005, 4'd3,  1'b0, 1'b0};
    vecs[4] = '{16'hA590, 4'd10, 16'h0909, 16'h0000, 4'd5,  1'b1, 1'b0};
    vecs[5] = '{16'hF0EF, 4'd15, 16'h0E0E, 16'h0F0F, 4'd0,  1'b0, 1'b1};
    vecs[6] = '{16'h0080, 4'd0,  16'h0808, 16'h0000, 4'd0,  1'b0, 1'b0};
    vecs[7] = '{16'h5000, 4'd5,  16'h0000, 16'h0000, 4'd0,  1'b0, 1'b1};
    vecs[8] = '{16'hB320, 4'd11, 16'h0202, 16'h0000, 4'd3,  1'b0, 1'b0};
    vecs[9] = '{16'h7DEF, 4'd7,  16'h0E0E, 16'h0F0F, 4'd13, 1'b1, 1'b1};

    // Reset state
    do_reset();
    chk("rst_alu_valid", alu_valid, 0);
    chk("rst_cmd", {func, OP0, OP1, flag_en, flag_in, dest, dest_we}, 0);
    chk("rst_ready", instr_ready, 1);

    // ADD r1,r2,r3 with R2=5, R3=7
    wb_write(2, 16'd5, 0);
    wb_write(3, 16'd7, 0);
    instr = 16'h1123; instr_valid = 1; #1;
    chk("add_ready", instr_ready, 1);
    tick();
    chk("add_cmd", {alu_valid, func, OP0, OP1, dest, dest_we, flag_en},
        {1'b1, 4'd1, 16'd5, 16'd7, 4'd1, 1'b1, 1'b1});
    // SUB r4,r1,r2 waits on r1
    instr = 16'h2412; #1;
    chk("sub_stall0", instr_ready, 0);
    tick();
    chk("sub_stall1", instr_ready, 0);
    wb_en = 1; wb_addr = 1; wb_data = 16'h000C; #1;
`ifdef WB_BYPASS_EN
    chk("sub_bypass_ready", instr_ready, 1);
    tick(); wb_en = 0;
`else
    chk("sub_wb_cycle_stall", instr_ready, 0);
    tick(); wb_en = 0; #1;
    chk("sub_after_wb_ready", instr_ready, 1);
    tick();
`endif
    instr_valid = 0;
    chk("sub_cmd", {alu_valid, func, OP0, OP1, dest}, {1'b1, 4'd2, 16'h000C, 16'd5, 4'd4});
    wb_write(4, 16'h0007, 1);

    // CMP then BEQ waits on flags
    instr = 16'hF023; instr_valid = 1;
    tick();
    instr = 16'hB010; #1;
    chk("beq_stall0", instr_ready, 0);
    tick();
    chk("beq_stall1", instr_ready, 0);
    wb_flag_en = 1; wb_flags = 4'b0100; #1;
`ifdef WB_BYPASS_EN
    chk("beq_bypass_ready", instr_ready, 1);
    tick(); wb_flag_en = 0;
`else
    chk("beq_wb_cycle_stall", instr_ready, 0);
    tick(); wb_flag_en = 0; #1;
    chk("beq_after_wb_ready", instr_ready, 1);
    tick();
`endif
    instr_valid = 0;
    chk("beq_cmd", {alu_valid, func, OP0, flag_in}, {1'b1, 4'd11, 16'h000C, 4'b0100});
    tick();

    // Downstream backpressure
    alu_ready = 0;
    instr = 16'h5223; instr_valid = 1;
    tick();
    instr = 16'h6533;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_ready", instr_ready, 0);
      tick();
      chk("bp_hold", {alu_valid, func, OP0, OP1, dest}, {1'b1, 4'd5, 16'd5, 16'd7, 4'd2});
    end
    alu_ready = 1; #1;
    chk("bp_release_ready", instr_ready, 1);
    tick();
    instr_valid = 0;
    chk("bp_next_cmd", {alu_valid, func, OP0, OP1, dest}, {1'b1, 4'd6, 16'd7, 16'd7, 4'd5});
    wb_write(2, 16'd5, 0);
    wb_write(5, 16'd7, 1);

    // MOV r0,r5 then read r0
    instr = 16'hA050; instr_valid = 1;
    tick();
    chk("mov_r0_cmd", {func, OP0, dest_we}, {4'd10, 16'd7, 1'b0});
    instr = 16'h1600; #1;
    chk("r0_read_ready", instr_ready, 1);
    tick();
    instr_valid = 0;
    chk("r0_read_op0", OP0, 16'd0);
    wb_write(6, 16'd0, 1);

    // Async reset mid-operation
    alu_ready = 0;
    instr = 16'h1123; instr_valid = 1;
    tick();
    instr_valid = 0;
    chk("pre_rst_valid", alu_valid, 1);
    #2 rst = 1;
    #1;
    chk("async_rst_valid", alu_valid, 0);
    tick();
    rst = 0; alu_ready = 1;
    instr = 16'h2210; instr_valid = 1; #1;
    chk("post_rst_ready", instr_ready, 1);
    tick();
    instr_valid = 0;
    chk("post_rst_cmd", {alu_valid, OP0}, {1'b1, 16'd0});

    // Table of decode vectors
    do_reset();
    for (int i = 1; i < 16; i++) wb_write(4'(i), 16'(i * 16'h0101), 0);
    foreach (vecs[i]) begin
      instr = vecs[i].instr; instr_valid = 1; #1;
      chk($sformatf("vec%0d_ready", i), instr_ready, 1);
      tick();
      instr_valid = 0;
      chk($sformatf("vec%0d_cmd", i),
          {alu_valid, func, OP0, OP1, dest, dest_we, flag_en, flag_in},
          {1'b1, vecs[i].func, vecs[i].op0, vecs[i].op1, vecs[i].dest,
           vecs[i].dwe, vecs[i].fe, 4'b0000});
      wb_write(vecs[i].dwe ? vecs[i].dest : 4'd0, 16'(vecs[i].dest * 16'h0101), 1);
    end

    // Randomized run against the reference model
    do_reset();
    model_reset();
    for (int i = 1; i < 16; i++) begin
      wb_write(4'(i), 16'($urandom), 0);
      m_regs[i] = wb_data;
    end
    for (int c = 0; c < 3000; c++) random_cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
